// File: rtl/axis_ram_writer_radar.sv
// AXI-Stream to AXI3 writer: buffers samples in a FIFO and writes fixed
// 16-beat INCR bursts into a circular DDR region based at min_addr.
module axis_ram_writer_radar #(
    parameter int ADDR_WIDTH       = 16,
    parameter int AXI_ID_WIDTH     = 6,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_WRITE_DEPTH = 512
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]     min_addr,
    input  logic [ADDR_WIDTH-1:0]         cfg_data,
    output logic [ADDR_WIDTH-1:0]         sts_data,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [3:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awcache,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int SHIFT = 4 + SIZE;
    localparam int PW    = $clog2(FIFO_WRITE_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [PW:0]                 rd_count;
    logic                        fifo_full;
    logic                        fifo_wr;
    logic                        fifo_rd;

    assign fifo_full     = rd_count == (PW+1)'(FIFO_WRITE_DEPTH);
    assign s_axis_tready = aresetn & ~fifo_full;
    assign fifo_wr       = s_axis_tvalid & s_axis_tready;
    assign fifo_rd       = m_axi_wvalid & m_axi_wready;

    always_ff @(posedge aclk) begin
        if (fifo_wr)
            mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_count <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   rd_count <= rd_count + 1'b1;
                2'b01:   rd_count <= rd_count - 1'b1;
                default: ;
            endcase
        end
    end

    // First-word-fall-through: the head word is always presented
    assign m_axi_wdata = mem[rd_ptr];

    state_t                    state, state_n;
    logic [ADDR_WIDTH-1:0]     addr_reg, addr_n;
    logic [ADDR_WIDTH-1:0]     limit_reg, limit_n;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_reg, awaddr_n;
    logic                      awvalid_reg, awvalid_n;
    logic                      wvalid_reg, wvalid_n;
    logic [3:0]                beat, beat_n;
    logic                      aw_done, aw_done_n;
    logic                      w_done, w_done_n;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      aw_ok;
    logic                      w_ok;

    assign aw_hs = awvalid_reg & m_axi_awready;
    assign w_hs  = wvalid_reg & m_axi_wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            addr_reg    <= '0;
            limit_reg   <= cfg_data;
            awaddr_reg  <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            beat        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            state       <= state_n;
            addr_reg    <= addr_n;
            limit_reg   <= limit_n;
            awaddr_reg  <= awaddr_n;
            awvalid_reg <= awvalid_n;
            wvalid_reg  <= wvalid_n;
            beat        <= beat_n;
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr_reg;
        limit_n   = limit_reg;
        awaddr_n  = awaddr_reg;
        awvalid_n = awvalid_reg;
        wvalid_n  = wvalid_reg;
        beat_n    = beat;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        aw_ok     = 1'b0;
        w_ok      = 1'b0;
        unique case (state)
            IDLE: begin
                // Sixteen words reserved up front, so the burst never starves
                if (rd_count >= (PW+1)'(16)) begin
                    state_n   = BURST;
                    awaddr_n  = min_addr
                              + (AXI_ADDR_WIDTH'(addr_reg) << SHIFT);
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    beat_n    = '0;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            BURST: begin
                aw_ok = aw_done | aw_hs;
                w_ok  = w_done | (w_hs & (beat == 4'd15));
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    beat_n = beat + 1'b1;
                    if (beat == 4'd15) begin
                        wvalid_n = 1'b0;
                        w_done_n = 1'b1;
                    end
                end
                if (aw_ok && w_ok) begin
                    state_n   = IDLE;
                    awvalid_n = 1'b0;
                    wvalid_n  = 1'b0;
                    // New cfg_data only takes effect at the wrap
                    if (addr_reg < limit_reg) begin
                        addr_n = addr_reg + 1'b1;
                    end else begin
                        addr_n  = {cfg_data[ADDR_WIDTH-1:ADDR_WIDTH-2],
                                   {(ADDR_WIDTH-2){1'b0}}};
                        limit_n = cfg_data;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic unused_bvalid;
    assign unused_bvalid = m_axi_bvalid;

    assign sts_data      = addr_reg;
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 4'd15;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0110;
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wid     = '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = beat == 4'd15;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = 1'b1;

endmodule

// File: doc/axis_ram_writer_radar.md
Name: axis_ram_writer_radar

Overview:
- AXI-Stream to AXI3 memory writer; the write-side counterpart of the radar RAM reader.
- Buffers incoming samples in a synchronous FIFO.
- Writes them to DDR as fixed 16-beat INCR bursts into a circular region based at min_addr.
- The wrap point and restart quarter come from cfg_data; sts_data reports the burst index currently being written, for software and reader synchronisation.

Parameters:
ADDR_WIDTH, 16, width of burst-index counter, cfg_data and sts_data (must be >= 3)
AXI_ID_WIDTH, 6, AXI ID width
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI write data width; power of two, >= 8
AXIS_TDATA_WIDTH, 64, input stream width; must equal AXI_DATA_WIDTH
FIFO_WRITE_DEPTH, 512, FIFO depth in words; power of two, >= 32

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
min_addr  in  AXI_ADDR_WIDTH  byte base address of buffer
cfg_data  in  ADDR_WIDTH  [MSB:MSB-1] restart quarter; full value = last burst index before wrap
sts_data  out  ADDR_WIDTH  current burst index
m_axi_awid  out  AXI_ID_WIDTH  constant 0
m_axi_awlen  out  4  constant 15
m_axi_awsize  out  3  constant log2(AXI_DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awcache  out  4  constant 4'b0110
m_axi_awaddr  out  AXI_ADDR_WIDTH  burst start address
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wid  out  AXI_ID_WIDTH  constant 0
m_axi_wdata  out  AXI_DATA_WIDTH  FIFO head word
m_axi_wstrb  out  AXI_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  high on beat 15
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  constant 1
s_axis_tdata  in  AXIS_TDATA_WIDTH  sample
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  ~fifo_full

Behaviour:
- aresetn is synchronous, active-low, on aclk.

FIFO
- First-word-fall-through FIFO, depth FIFO_WRITE_DEPTH.
- Write on s_axis_tvalid & s_axis_tready.
- Pop on m_axi_wvalid & m_axi_wready.
- rd_count is the occupancy.

State machine (IDLE, BURST)
- IDLE: when rd_count >= 16, go to BURST next cycle.
  - Load awaddr = min_addr + (addr_reg << (4 + log2(AXI_DATA_WIDTH/8))).
  - Set awvalid=1, wvalid=1, beat=0.
- BURST, address channel: awvalid stays high until awready is sampled high, then drops; awaddr is held stable meanwhile.
- BURST, data channel:
  - wvalid stays high throughout; 16 words were reserved at entry, so the FIFO never underflows.
  - beat increments on each wvalid & wready.
  - wlast = (beat == 15).
- The address and data channels are independent: data may complete before the address handshake or vice versa, and awready and wready may be high in the same cycle.
- Burst done = address accepted and the beat-15 handshake done, including when both occur in the same cycle.
- On burst done:
  - Return to IDLE and drop wvalid.
  - If addr_reg < limit_reg: addr_reg += 1.
  - Else: addr_reg <= {cfg_data[MSB:MSB-1], zeros} and limit_reg <= cfg_data, so a new cfg_data takes effect only at the wrap.
- Minimum one IDLE cycle between bursts.

Write responses
- B responses are accepted and ignored; bready is tied high.

Status
- sts_data = addr_reg, updated the cycle after burst done.

Reset
- addr_reg=0, limit_reg<=cfg_data, state=IDLE, beat=0, awvalid=0, wvalid=0, awaddr=0, FIFO flushed.
- s_axis_tready=0 while reset is asserted.
- A reset mid-burst abandons the burst immediately; the system resets the interconnect together with this block.

Test Plan:
- Reset, then cfg_data=16'h0003, min_addr=32'h1000_0000, 64 samples 0..63 with slave always ready -> 4 bursts at 0x1000_0000, 0x1000_0080, 0x1000_0100, 0x1000_0180; wdata sequential 0..63; wlast on beats 15/31/47/63; sts_data 0->1->2->3->0.
- Feed 15 samples only -> no awvalid/wvalid; 16th sample -> awvalid asserts within 2 cycles.
- awready delayed 20 cycles while wready=1 -> all 16 beats complete first; awaddr stable; a single burst done; next burst starts only after awready.
- Random wready/awready backpressure, 1024 samples -> written data matches the input order exactly; no beat popped without a handshake.
- Change cfg_data to 16'h4001 mid-run (old limit 3) -> old limit honoured until the wrap; then addr_reg=0x4000; next wrap at 0x4001.
- Stall the slave with the FIFO full -> s_axis_tready=0 and no sample lost; assert aresetn=0 mid-burst -> next cycle awvalid=wvalid=0, sts_data=0.
